skinny_sbox_layer_sched_d1: RTL and testbench

Sequencer that applies one shared first-order masked Skinny-64 S-box instance to all 16 nibbles of a 64-bit two-share state.
- For each nibble it fetches 21 fresh random bits, arms the clock-gated HPC2 S-box and holds its inputs stable.
- It waits for the S-box `Synch` pulse, then writes the result shares back into the matching nibble.
- It sits between the round controller (start/valid handshake) and a single S-box instance, trading latency for area.

---
 rtl/skinny_sbox_layer_sched_d1.sv | 218 +++++++++++++++++++++
 tb/tb_skinny_sbox_layer_sched_d1.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/skinny_sbox_layer_sched_d1.sv
// ---------------------------------------------------------------------------
// skinny_sbox_layer_sched_d1
//
// Applies one shared first-order masked Skinny-64 S-box instance to every
// nibble of a two-share state. The nibbles are processed one at a time. For
// each nibble the block:
//   1. fetches a 21-bit fresh random word,
//   2. arms the S-box with a one-cycle controller reset,
//   3. holds the S-box inputs stable until the S-box raises its Synch pulse,
//   4. writes the S-box result shares back into the same nibble position.
// This trades latency for area. Share 0 and share 1 are never combined.
// Every register and every mux handles one share only.
//
// Ports
//   clk, rst               clock; synchronous active-high reset
//   start / ready          layer request handshake (accept = start && ready)
//   in_s0, in_s1           input state shares, sampled on accept
//   out_s0, out_s1         result shares, valid while out_valid
//   out_valid / out_ready  result handshake
//   err                    sticky timeout flag, cleared by the next accept
//   rnd_in / rnd_valid     fresh randomness source
//   rnd_ready              the block consumes rnd_in this cycle if rnd_valid
//   sb_x_s0, sb_x_s1       registered S-box input shares
//   sb_fresh               registered S-box randomness
//   sb_rst                 S-box controller reset (rst OR arming cycle)
//   sb_synch               S-box result-valid pulse
//   sb_y_s0, sb_y_s1       S-box output shares
// ---------------------------------------------------------------------------
module skinny_sbox_layer_sched_d1 #(
    parameter int NIBBLES = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   ready,
    input  logic [4*NIBBLES-1:0]   in_s0,
    input  logic [4*NIBBLES-1:0]   in_s1,
    output logic [4*NIBBLES-1:0]   out_s0,
    output logic [4*NIBBLES-1:0]   out_s1,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   err,
    input  logic [20:0]            rnd_in,
    input  logic                   rnd_valid,
    output logic                   rnd_ready,
    output logic [3:0]             sb_x_s0,
    output logic [3:0]             sb_x_s1,
    output logic [20:0]            sb_fresh,
    output logic                   sb_rst,
    input  logic                   sb_synch,
    input  logic [3:0]             sb_y_s0,
    input  logic [3:0]             sb_y_s1
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NIBBLES - 1);
    // The counter holds the number of WAIT cycles already completed. The
    // timeout therefore fires during the TIMEOUT-th WAIT cycle.
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_ARM   = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] wait_cnt;
    logic [W-1:0]     work_s0;
    logic [W-1:0]     work_s1;
    logic             err_q;
    logic [3:0]       x_s0_q;
    logic [3:0]       x_s1_q;
    logic [20:0]      fresh_q;

    logic             accept;
    logic             fetch_go;
    logic             synch_hit;
    logic             timed_out;
    logic             last_nib;
    logic [IDX_W+1:0] nib_lsb;

    // Event decode. sb_synch counts only in WAIT. In the final WAIT cycle a
    // Synch pulse takes priority over the timeout.
    assign accept    = (state == ST_IDLE) && start;
    assign fetch_go  = (state == ST_FETCH) && rnd_valid;
    assign synch_hit = (state == ST_WAIT) && sb_synch;
    assign timed_out = (state == ST_WAIT) && !sb_synch && (wait_cnt == CNT_LIMIT);
    assign last_nib  = (idx == LAST_IDX);
    assign nib_lsb   = {idx, 2'b00};

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (rnd_valid) begin
                    state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (sb_synch) begin
                    state_nxt = last_nib ? ST_DONE : ST_FETCH;
                end else if (wait_cnt == CNT_LIMIT) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (accept) begin
            idx <= '0;
        end else if (synch_hit && !last_nib) begin
            idx <= idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == ST_ARM) begin
            wait_cnt <= '0;
        end else if ((state == ST_WAIT) && !sb_synch && !timed_out) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Working shares. A timeout discards the partially processed state so
    // that no half-substituted value stays in the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            work_s0 <= '0;
            work_s1 <= '0;
        end else if (accept) begin
            work_s0 <= in_s0;
            work_s1 <= in_s1;
        end else if (timed_out) begin
            work_s0 <= '0;
            work_s1 <= '0;
        end else if (synch_hit) begin
            work_s0[nib_lsb +: 4] <= sb_y_s0;
            work_s1[nib_lsb +: 4] <= sb_y_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (timed_out) begin
            err_q <= 1'b1;
        end
    end

    // S-box operands are loaded only on the FETCH->ARM edge. They stay
    // frozen through ARM and WAIT, which the clock-gated HPC2 S-box requires.
    // Each fresh word is therefore used for exactly one nibble.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_s0_q  <= '0;
            x_s1_q  <= '0;
            fresh_q <= '0;
        end else if (fetch_go) begin
            x_s0_q  <= work_s0[nib_lsb +: 4];
            x_s1_q  <= work_s1[nib_lsb +: 4];
            fresh_q <= rnd_in;
        end
    end

    assign ready     = (state == ST_IDLE);
    assign rnd_ready = (state == ST_FETCH);
    assign out_valid = (state == ST_DONE);
    assign err       = err_q;
    assign sb_x_s0   = x_s0_q;
    assign sb_x_s1   = x_s1_q;
    assign sb_fresh  = fresh_q;
    // The S-box controller is held in reset whenever this block is reset,
    // not only during the arming cycle.
    assign sb_rst    = rst | (state == ST_ARM);
    // The outputs are gated so that no working-share data is visible
    // outside DONE.
    assign out_s0    = out_valid ? work_s0 : '0;
    assign out_s1    = out_valid ? work_s1 : '0;

endmodule

// File: tb/tb_skinny_sbox_layer_sched_d1.sv
// ---------------------------------------------------------------------------
// tb_skinny_sbox_layer_sched_d1
//
// Directed bench for the masked S-box layer sequencer.
// - A behavioural S-box model pulses Synch in the chosen WAIT cycle.
// - A randomness source hands out distinct 21-bit words.
// - A monitor predicts the result shares from the S-box table and the words
//   actually consumed. Every cycle it checks operand stability, the latched
//   operands and, while out_valid is high, the result and its timing.
// ---------------------------------------------------------------------------
module tb_skinny_sbox_layer_sched_d1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ready;
    logic [63:0] in_s0;
    logic [63:0] in_s1;
    logic [63:0] out_s0;
    logic [63:0] out_s1;
    logic        out_valid;
    logic        out_ready;
    logic        err;
    logic [20:0] rnd_in;
    logic        rnd_valid;
    logic        rnd_ready;
    logic [3:0]  sb_x_s0;
    logic [3:0]  sb_x_s1;
    logic [20:0] sb_fresh;
    logic        sb_rst;
    logic        sb_synch;
    logic [3:0]  sb_y_s0;
    logic [3:0]  sb_y_s1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Scenario knobs.
    int          sb_lat        = 9;
    bit          sb_dead       = 1'b0;
    bit          stall_en      = 1'b0;
    int          stall_left    = 0;
    bit          spur_en       = 1'b0;
    bit          force_synch   = 1'b0;
    bit          expect_result = 1'b0;
    int          exp_valid_rel = 0;
    logic [63:0] exp_plain     = '0;

    // Monitor state.
    logic [20:0] rndq[$];
    int          accept_cyc = 0;
    bit          seen_valid = 1'b0;
    logic [63:0] acc_s0     = '0;
    logic [3:0]  prev_x0    = '0;
    logic [3:0]  prev_x1    = '0;
    logic [20:0] prev_fresh = '0;
    logic [20:0] prev_rnd   = '0;
    bit          prev_take  = 1'b0;
    bit          prev_rst   = 1'b1;
    bit          take;
    int          k;
    logic [63:0] exp0;
    logic [63:0] exp1;
    int          dups;

    // S-box model state.
    int sb_cnt     = 0;
    bit sb_armed   = 1'b0;
    bit prev_sbrst = 1'b0;
    bit model_syn;

    // Randomness source state.
    int rnd_seq   = 0;
    bit last_take = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    skinny_sbox_layer_sched_d1 #(.NIBBLES(16), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready),
        .in_s0(in_s0), .in_s1(in_s1), .out_s0(out_s0), .out_s1(out_s1),
        .out_valid(out_valid), .out_ready(out_ready), .err(err),
        .rnd_in(rnd_in), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .sb_x_s0(sb_x_s0), .sb_x_s1(sb_x_s1), .sb_fresh(sb_fresh),
        .sb_rst(sb_rst), .sb_synch(sb_synch), .sb_y_s0(sb_y_s0), .sb_y_s1(sb_y_s1)
    );

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        case (x)
            4'h0: return 4'hc;  4'h1: return 4'h6;  4'h2: return 4'h9;  4'h3: return 4'h0;
            4'h4: return 4'h1;  4'h5: return 4'ha;  4'h6: return 4'h2;  4'h7: return 4'hb;
            4'h8: return 4'h3;  4'h9: return 4'h8;  4'ha: return 4'h5;  4'hb: return 4'hd;
            4'hc: return 4'h4;  4'hd: return 4'he;  4'he: return 4'h7;  default: return 4'hf;
        endcase
    endfunction

    function automatic logic [63:0] sbox_layer(input logic [63:0] v);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = sbox4(v[4*i +: 4]);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // S-box model.
    // - It counts WAIT cycles from its controller reset.
    // - It pulses Synch in the sb_lat-th cycle.
    // - Result: y_s1 = fresh[3:0], y_s0 = S(x) ^ fresh[3:0].
    initial begin
        sb_synch = 1'b0;
        sb_y_s0  = '0;
        sb_y_s1  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (prev_sbrst) begin
                sb_armed = 1'b1;
                sb_cnt   = 1;
            end else if (sb_armed) begin
                if (sb_cnt == sb_lat) sb_armed = 1'b0;
                else sb_cnt++;
            end
            model_syn = sb_armed && !sb_dead && (sb_cnt == sb_lat);
            sb_synch  = model_syn || force_synch;
            sb_y_s0   = sbox4(sb_x_s0 ^ sb_x_s1) ^ sb_fresh[3:0];
            sb_y_s1   = sb_fresh[3:0];
            #3;
            prev_sbrst = sb_rst;
        end
    end

    // Randomness source. It also injects the rnd_valid stall and the
    // spurious Synch pulse in FETCH.
    initial begin
        rnd_valid = 1'b0;
        rnd_in    = {5'd0, 16'($urandom)};
        forever begin
            @(negedge clk);
            if (last_take) begin
                rnd_seq++;
                rnd_in = {rnd_seq[4:0], 16'($urandom)};
            end
            if (rnd_ready && stall_en && rndq.size() == 5 && stall_left > 0) begin
                rnd_valid = 1'b0;
                stall_left--;
            end else begin
                rnd_valid = 1'b1;
            end
            force_synch = rnd_ready && spur_en && (rndq.size() == 3);
            last_take   = rnd_ready && rnd_valid;
        end
    end

    // Monitor / compare process.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (start && ready && !rst) begin
                accept_cyc = cyc;
                rndq.delete();
                seen_valid = 1'b0;
                acc_s0     = in_s0;
            end
            if (!prev_rst) begin
                if (prev_take) begin
                    k = rndq.size() - 1;
                    if (k < 0) k = 0;
                    checkOutput("fresh_latch", 64'(sb_fresh), 64'(prev_rnd));
                    checkOutput("x_latch", 64'(sb_x_s0), 64'(acc_s0[4*k +: 4]));
                end else begin
                    checkOutput("sbox_in_stable", 64'({sb_x_s0, sb_x_s1, sb_fresh}),
                                64'({prev_x0, prev_x1, prev_fresh}));
                end
            end
            take = rnd_ready && rnd_valid;
            if (take) rndq.push_back(rnd_in);
            if (out_valid) begin
                checkOutput("valid_expected", 64'(out_valid), 64'(expect_result));
                if (!seen_valid) begin
                    seen_valid = 1'b1;
                    checkOutput("valid_cycle", 64'(cyc - accept_cyc), 64'(exp_valid_rel));
                end
                checkOutput("word_count", 64'(rndq.size()), 64'd16);
                exp0 = '0;
                exp1 = '0;
                dups = 0;
                for (int i = 0; i < 16 && i < rndq.size(); i++) begin
                    exp1[4*i +: 4] = rndq[i][3:0];
                    exp0[4*i +: 4] = sbox4(exp_plain[4*i +: 4]) ^ rndq[i][3:0];
                    for (int j = 0; j < i; j++) if (rndq[j] == rndq[i]) dups++;
                end
                checkOutput("rnd_distinct", 64'(dups), 64'd0);
                checkOutput("out_share0", out_s0, exp0);
                checkOutput("out_share1", out_s1, exp1);
                checkOutput("out_recombined", out_s0 ^ out_s1, sbox_layer(exp_plain));
            end
            prev_take  = take;
            prev_rnd   = rnd_in;
            prev_x0    = sb_x_s0;
            prev_x1    = sb_x_s1;
            prev_fresh = sb_fresh;
            prev_rst   = rst;
        end
    end

    task automatic applyStimulus(input logic [63:0] s0, input logic [63:0] s1);
        int n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_before_start", 64'(ready), 64'd1);
        in_s0 = s0;
        in_s1 = s1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_s0 = ~s0;
        in_s1 = ~s1;
        checkOutput("err_cleared", 64'(err), 64'd0);
        checkOutput("busy_after_accept", 64'(ready), 64'd0);
    endtask

    task automatic runLayer(input logic [63:0] plain, input logic [63:0] mask,
                            input logic [63:0] lit_result, input int exp_rel, input int hold);
        int n = 0;
        exp_plain     = plain;
        exp_valid_rel = exp_rel;
        expect_result = 1'b1;
        out_ready     = (hold == 0);
        applyStimulus(plain ^ mask, mask);
        while (!out_valid && n < 600) begin
            @(negedge clk);
            n++;
        end
        checkOutput("valid_seen", 64'(out_valid), 64'd1);
        checkOutput("recombined_literal", out_s0 ^ out_s1, lit_result);
        if (hold > 0) begin
            logic [63:0] snap0;
            logic [63:0] snap1;
            snap0 = out_s0;
            snap1 = out_s1;
            repeat (hold) begin
                @(negedge clk);
                checkOutput("hold_valid", 64'(out_valid), 64'd1);
                checkOutput("hold_s0", out_s0, snap0);
                checkOutput("hold_s1", out_s1, snap1);
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        checkOutput("ready_after_done", 64'(ready), 64'd1);
        checkOutput("valid_after_done", 64'(out_valid), 64'd0);
        expect_result = 1'b0;
        out_ready     = 1'b1;
    endtask

    localparam logic [63:0] PLAIN = 64'h0123456789ABCDEF;
    localparam logic [63:0] RESLT = 64'hC6901A2B385D4E7F;

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_s0     = '0;
        in_s1     = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        $display("[TB] reset values");
        checkOutput("rst_ready", 64'(ready), 64'd1);
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        checkOutput("rst_rnd_ready", 64'(rnd_ready), 64'd0);
        checkOutput("rst_out", out_s0 | out_s1, 64'd0);
        checkOutput("rst_sbox_in", 64'({sb_x_s0, sb_x_s1, sb_fresh}), 64'd0);
        checkOutput("rst_sb_rst", 64'(sb_rst), 64'd1);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] nominal layer");
        runLayer(PLAIN, 64'd0, RESLT, 177, 0);

        $display("[TB] randomized shares");
        runLayer(PLAIN, {$urandom, $urandom}, RESLT, 177, 0);

        $display("[TB] randomness stall");
        stall_en   = 1'b1;
        stall_left = 3;
        runLayer(PLAIN, {$urandom, $urandom}, RESLT, 180, 0);
        stall_en   = 1'b0;

        $display("[TB] output backpressure");
        runLayer(PLAIN, {$urandom, $urandom}, RESLT, 177, 10);

        $display("[TB] spurious synch and start");
        spur_en = 1'b1;
        fork
            runLayer(PLAIN, 64'd0, RESLT, 177, 0);
            begin
                repeat (30) @(negedge clk);
                start = 1'b1;
                in_s0 = 64'hFFFF0000FFFF0000;
                repeat (4) begin
                    @(negedge clk);
                    checkOutput("busy_ignores_start", 64'(ready), 64'd0);
                end
                start = 1'b0;
            end
        join
        spur_en = 1'b0;

        $display("[TB] timeout");
        begin
            int rel = 1;
            sb_dead = 1'b1;
            applyStimulus(PLAIN, 64'd0);
            while (!err && rel < 60) begin
                @(negedge clk);
                rel++;
            end
            checkOutput("timeout_cycle", 64'(rel), 64'd18);
            checkOutput("timeout_ready", 64'(ready), 64'd1);
            checkOutput("timeout_valid", 64'(out_valid), 64'd0);
            sb_dead = 1'b0;
            repeat (3) @(negedge clk);
            checkOutput("err_sticky", 64'(err), 64'd1);
        end
        runLayer(PLAIN, {$urandom, $urandom}, RESLT, 177, 0);

        $display("[TB] reset mid-layer");
        applyStimulus(PLAIN, 64'd0);
        repeat (49) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("sb_rst_follows_rst", 64'(sb_rst), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abort_ready", 64'(ready), 64'd1);
        checkOutput("abort_valid", 64'(out_valid), 64'd0);
        checkOutput("abort_err", 64'(err), 64'd0);
        checkOutput("abort_rnd_ready", 64'(rnd_ready), 64'd0);
        checkOutput("abort_out", out_s0 | out_s1, 64'd0);
        checkOutput("abort_sbox_in", 64'({sb_x_s0, sb_x_s1, sb_fresh}), 64'd0);
        checkOutput("abort_sb_rst", 64'(sb_rst), 64'd0);
        repeat (200) @(negedge clk);
        checkOutput("abort_stays_idle", 64'(ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog");
    end

endmodule
